// File: rtl/unsigned_mul_8x8_ha_reducer_pkg.sv
// rtl/unsigned_mul_8x8_ha_reducer_pkg.sv - shared widths and FSM state type for the HA-array product reducer
package unsigned_mul_8x8_ha_reducer_pkg;

  localparam int NUM_ARRAYS = 4;
  localparam int B_W        = 7;   // carry (bottom) row width
  localparam int T_W        = 9;   // sum (top) row width
  localparam int ROW_W      = 10;  // one array's row value, max 1019
  localparam int ACC_W      = 17;  // product plus overflow bit
  localparam int PROD_W     = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/unsigned_mul_8x8_ha_reducer_ha_row.sv
// rtl/unsigned_mul_8x8_ha_reducer_ha_row.sv - combinational row value of one half-adder array
//
// Ports:
//   b   - bottom (carry) row, bit k weighs 2^(k+2)
//   t   - top (sum) row, bit k weighs 2^k
//   row - weighted sum of both rows, 10 bits (max 511 + 508 = 1019)
module ha_row_value
  import unsigned_mul_8x8_ha_reducer_pkg::*;
(
  input  logic [B_W-1:0]   b,
  input  logic [T_W-1:0]   t,
  output logic [ROW_W-1:0] row
);

  // Carry bits sit two columns left of the matching sum bits.
  assign row = ROW_W'(t) + (ROW_W'(b) << 2);

endmodule

// File: rtl/unsigned_mul_8x8_ha_reducer.sv
// rtl/unsigned_mul_8x8_ha_reducer.sv - sequential reducer summing four shifted HA-array rows into a 16-bit product
//
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   in_valid, in_ready  - bundle handshake; ready only in IDLE
//   ha_array_<i>_b/_t   - bottom/top rows of array i (i = 0..3)
//   out_valid, out_ready- result handshake; valid only in DONE
//   prod, ovf           - sum modulo 2^16 and its bit 16
//
// A bundle accepted in cycle N spends N+1..N+4 accumulating one array per
// cycle and presents its result from N+5 until out_ready.
module unsigned_mul_8x8_ha_reducer
  import unsigned_mul_8x8_ha_reducer_pkg::*;
#(
  parameter int NUM_ARRAYS = 4,
  parameter int PROD_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [B_W-1:0]    ha_array_0_b,
  input  logic [B_W-1:0]    ha_array_1_b,
  input  logic [B_W-1:0]    ha_array_2_b,
  input  logic [B_W-1:0]    ha_array_3_b,
  input  logic [T_W-1:0]    ha_array_0_t,
  input  logic [T_W-1:0]    ha_array_1_t,
  input  logic [T_W-1:0]    ha_array_2_t,
  input  logic [T_W-1:0]    ha_array_3_t,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] prod,
  output logic              ovf
);

  localparam logic [1:0] LAST_IDX = 2'(NUM_ARRAYS - 1);

  state_t state, state_nxt;

  logic [ACC_W-1:0] acc;
  logic [1:0]       idx;
  logic [B_W-1:0]   cap_b [4];
  logic [T_W-1:0]   cap_t [4];

  logic [ROW_W-1:0] row;
  logic [ACC_W-1:0] row_shifted;
  logic             accept;

  // Hold ready low during reset so nothing is accepted in that cycle.
  assign in_ready  = (state == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign prod      = acc[PROD_W-1:0];
  assign ovf       = acc[ACC_W-1];

  // One row evaluator shared across the four captured arrays.
  ha_row_value u_row (
    .b   (cap_b[idx]),
    .t   (cap_t[idx]),
    .row (row)
  );

  assign row_shifted = ACC_W'(row) << {idx, 1'b0};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ACC;
      ACC:     if (idx == LAST_IDX) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      acc   <= '0;
      idx   <= '0;
      for (int i = 0; i < 4; i++) begin
        cap_b[i] <= '0;
        cap_t[i] <= '0;
      end
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (accept) begin
            acc      <= '0;
            idx      <= '0;
            cap_b[0] <= ha_array_0_b;
            cap_b[1] <= ha_array_1_b;
            cap_b[2] <= ha_array_2_b;
            cap_b[3] <= ha_array_3_b;
            cap_t[0] <= ha_array_0_t;
            cap_t[1] <= ha_array_1_t;
            cap_t[2] <= ha_array_2_t;
            cap_t[3] <= ha_array_3_t;
          end
        end
        ACC: begin
          acc <= acc + row_shifted;
          idx <= idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_unsigned_mul_8x8_ha_reducer.sv
// tb/tb_unsigned_mul_8x8_ha_reducer.sv - self-checking bench for the HA-array product reducer
module tb_unsigned_mul_8x8_ha_reducer;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [3:0][6:0]  b_drv;
  logic [3:0][8:0]  t_drv;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      prod;
  logic             ovf;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  unsigned_mul_8x8_ha_reducer #(.NUM_ARRAYS(4), .PROD_W(16)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .ha_array_0_b (b_drv[0]),
    .ha_array_1_b (b_drv[1]),
    .ha_array_2_b (b_drv[2]),
    .ha_array_3_b (b_drv[3]),
    .ha_array_0_t (t_drv[0]),
    .ha_array_1_t (t_drv[1]),
    .ha_array_2_t (t_drv[2]),
    .ha_array_3_t (t_drv[3]),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .prod         (prod),
    .ovf          (ovf)
  );

  typedef struct {
    logic [3:0][6:0] b;
    logic [3:0][8:0] t;
    int              exp_prod;
    bit              exp_ovf;
    int              stall;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: the full true sum, from bit weights alone.
  function automatic int model_sum(input logic [3:0][6:0] b, input logic [3:0][8:0] t);
    int s = 0;
    for (int i = 0; i < 4; i++) begin
      int row = 0;
      for (int k = 0; k < 9; k++) if (t[i][k]) row += 2 ** k;
      for (int k = 0; k < 7; k++) if (b[i][k]) row += 2 ** (k + 2);
      s += row * (4 ** i);
    end
    return s;
  endfunction

  task automatic scramble_inputs();
    for (int i = 0; i < 4; i++) begin
      b_drv[i] = 7'($urandom);
      t_drv[i] = 9'($urandom);
    end
  endtask

  // Offers one bundle, checks latency, result and stall behaviour.
  task automatic send(input logic [3:0][6:0] b, input logic [3:0][8:0] t,
                      input int exp_prod, input bit exp_ovf, input int stall,
                      input string tag);
    int n;
    int acc_cyc;
    logic [15:0] held_p;
    logic        held_o;
    @(negedge clk);
    n = 0;
    while (!in_ready && n < 20) begin @(negedge clk); n++; end
    check({tag, "_in_ready_before"}, int'(in_ready), 1);
    b_drv = b;
    t_drv = t;
    in_valid = 1'b1;
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0;
    scramble_inputs();
    check({tag, "_in_ready_busy"}, int'(in_ready), 0);
    n = 0;
    while (!out_valid && n < 20) begin
      in_valid = 1'b1;
      @(negedge clk);
      scramble_inputs();
      n++;
    end
    in_valid = 1'b0;
    check({tag, "_latency"}, cyc - acc_cyc, 5);
    check({tag, "_prod"}, int'(prod), exp_prod);
    check({tag, "_ovf"}, int'(ovf), int'(exp_ovf));
    held_p = prod;
    held_o = ovf;
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check({tag, "_stall_valid"}, int'(out_valid), 1);
      check({tag, "_stall_prod"}, int'(prod), int'(held_p));
      check({tag, "_stall_ovf"}, int'(ovf), int'(held_o));
      check({tag, "_stall_in_ready"}, int'(in_ready), 0);
    end
    out_ready = 1'b1;
    check({tag, "_no_overlap"}, int'(in_ready), 0);
    @(negedge clk);
    out_ready = 1'b0;
    check({tag, "_valid_drop"}, int'(out_valid), 0);
    check({tag, "_in_ready_after"}, int'(in_ready), 1);
  endtask

  initial begin
    logic [3:0][6:0] rb;
    logic [3:0][8:0] rt;
    int s;
    int n;
    bit seen;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    b_drv = '0;
    t_drv = '0;

    for (int i = 0; i < 6; i++) begin
      vecs[i].b = '0;
      vecs[i].t = '0;
      vecs[i].stall = 0;
    end
    vecs[0].exp_prod = 0;     vecs[0].exp_ovf = 1'b0;
    vecs[1].t[0] = 9'h001;
    vecs[1].exp_prod = 1;     vecs[1].exp_ovf = 1'b0;
    vecs[2].b[3] = 7'h40;
    vecs[2].exp_prod = 16384; vecs[2].exp_ovf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      vecs[3].b[i] = 7'h7f;
      vecs[3].t[i] = 9'h1ff;
    end
    vecs[3].exp_prod = 21079; vecs[3].exp_ovf = 1'b1; vecs[3].stall = 3;
    vecs[4].t[1] = 9'h1ff;
    vecs[4].exp_prod = 2044;  vecs[4].exp_ovf = 1'b0;
    vecs[5].b[0] = 7'h01; vecs[5].t[2] = 9'h100;
    vecs[5].exp_prod = 4100;  vecs[5].exp_ovf = 1'b0; vecs[5].stall = 1;

    repeat (3) @(negedge clk);
    check("reset_in_ready", int'(in_ready), 0);
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_prod", int'(prod), 0);
    check("reset_ovf", int'(ovf), 0);
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_in_ready", int'(in_ready), 1);

    for (int i = 0; i < 6; i++)
      send(vecs[i].b, vecs[i].t, vecs[i].exp_prod, vecs[i].exp_ovf, vecs[i].stall,
           $sformatf("vec%0d", i));

    // Reset two cycles after acceptance discards the bundle in flight.
    @(negedge clk);
    b_drv = vecs[3].b;
    t_drv = vecs[3].t;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", int'(in_ready), 0);
    rst = 1'b0;
    out_ready = 1'b0;
    seen = 1'b0;
    n = 0;
    @(negedge clk);
    check("midrst_in_ready_after", int'(in_ready), 1);
    while (n < 8) begin
      if (out_valid) seen = 1'b1;
      @(negedge clk);
      n++;
    end
    check("midrst_no_out_valid", int'(seen), 0);
    check("midrst_prod_cleared", int'(prod), 0);
    send(vecs[5].b, vecs[5].t, vecs[5].exp_prod, vecs[5].exp_ovf, 0, "after_rst");

    // Random bundles with random consumer stalls.
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < 4; i++) begin
        rb[i] = 7'($urandom);
        rt[i] = 9'($urandom);
      end
      s = model_sum(rb, rt);
      send(rb, rt, s % 65536, bit'((s / 65536) % 2), int'($urandom_range(0, 3)),
           $sformatf("rand%0d", r));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/unsigned_mul_8x8_ha_reducer.md
UNSIGNED_MUL_8X8_HA_REDUCER -- requirements
Module: unsigned_mul_8x8_ha_reducer

Interface
REQ-001 SHALL have parameter NUM_ARRAYS, default 4, meaning the number of half-adder arrays per bundle.
REQ-002 SHALL have parameter PROD_W, default 16, meaning the product width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port in_valid, input, 1 bit: an input bundle is presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the block accepts a bundle this cycle.
REQ-007 SHALL have ports ha_array_i_b, input, 7 bits, for i = 0..3: bottom (carry) row of array i.
REQ-008 SHALL have ports ha_array_i_t, input, 9 bits, for i = 0..3: top (sum) row of array i.
REQ-009 SHALL have port out_valid, output, 1 bit: prod and ovf are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 SHALL have port prod, output, PROD_W bits: reduced product, modulo 2^16.
REQ-012 SHALL have port ovf, output, 1 bit: the true sum exceeded 65535.

Function
REQ-013 Row value of array i SHALL be sum(t[k]·2^k, k=0..8) + sum(b[k]·2^(k+2), k=0..6), held 10 bits wide; max 1019.
REQ-014 Array i SHALL contribute its row value shifted left by 2·i.
REQ-015 The bundle SHALL be accepted on in_valid && in_ready; all eight input vectors SHALL be captured into registers that cycle.
REQ-016 FSM states SHALL be IDLE, ACC and DONE; in_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE, on accept: the 17-bit accumulator SHALL be cleared, the array index SHALL be set to 0, and the FSM SHALL go to ACC.
REQ-018 In ACC, each cycle SHALL add the shifted row value of the captured array[index] and increment index; after index 3 the FSM SHALL go to DONE.
REQ-019 Latency: a bundle accepted in cycle N SHALL have out_valid asserted from cycle N+5.
REQ-020 In DONE, out_valid SHALL be 1, prod SHALL equal acc[15:0], and ovf SHALL equal acc[16].
REQ-021 prod and ovf SHALL be held stable while out_valid && !out_ready.
REQ-022 DONE SHALL return to IDLE on out_ready; in_ready SHALL rise the following cycle, with no same-cycle in/out overlap.
REQ-023 Throughput SHALL be at most 1 bundle per 6 cycles.
REQ-024 Input changes while not in IDLE SHALL be ignored.
REQ-025 in_valid asserted in IDLE SHALL be accepted the same cycle; there is no input buffering.

Reset
REQ-026 On rst: state SHALL be IDLE, accumulator 0, index 0, captured registers 0, out_valid 0, prod 0, ovf 0.
REQ-027 While rst is high, in_ready SHALL be 0; it SHALL be 1 from the first cycle after rst deasserts.
REQ-028 rst in ACC or DONE SHALL discard the bundle in flight, and no out_valid SHALL appear for it.

Structure
REQ-029 A shared package SHALL hold NUM_ARRAYS=4, B_W=7, T_W=9, ROW_W=10, ACC_W=17, PROD_W=16 and the state enum {IDLE, ACC, DONE}.
REQ-030 Sub-module ha_row_value (combinational: b, t -> 10-bit row value) SHALL be instantiated once and muxed by index.

Verification
REQ-031 All inputs 0, accept, out_ready=1 -> out_valid at N+5 with prod=0, ovf=0.
REQ-032 Only ha_array_0_t[0]=1 -> prod=1; only ha_array_3_b[6]=1 -> prod=16384, ovf=0.
REQ-033 All b and t bits 1 in all four arrays -> sum 1019·85=86615 -> prod=21079, ovf=1.
REQ-034 out_ready held 0 for 3 cycles in DONE -> prod stable and in_ready=0 throughout; release -> in_ready=1 the next cycle.
REQ-035 rst pulsed at N+2 mid-ACC -> no out_valid for that bundle; a new bundle afterwards gives its correct product at its own acceptance +5.
REQ-036 Random b/t bundles, back-to-back with random out_ready -> every prod matches the REQ-013/014 model mod 2^16, and ovf matches bit 16.
